rect_raster: RTL and testbench



---
 rtl/block_shooter_pkg.sv | 20 ++
 rtl/rect_raster.sv | 177 +++++++++++++++++
 tb/tb_rect_raster.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/block_shooter_pkg.sv
// Shared constants and types for the block shooter display path.
// Defines frame geometry, field widths, the erase colour and the rasterizer state encoding.
package block_shooter_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int XW       = 8;
    localparam int YW       = 7;
    localparam int CW       = 3;
    localparam int DW       = 5;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } raster_state_t;

endpackage

// File: rtl/rect_raster.sv
// Rectangle rasterizer: accepts one rectangle request and streams its pixels row-major,
// one per clock, suppressing plot for pixels outside the frame, then pulses done.
module rect_raster #(
    parameter int SCREEN_W = block_shooter_pkg::SCREEN_W,
    parameter int SCREEN_H = block_shooter_pkg::SCREEN_H,
    parameter int XW       = block_shooter_pkg::XW,
    parameter int YW       = block_shooter_pkg::YW,
    parameter int CW       = block_shooter_pkg::CW,
    parameter int DW       = block_shooter_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [XW-1:0] req_x,
    input  logic [YW-1:0] req_y,
    input  logic [DW-1:0] req_w,
    input  logic [DW-1:0] req_h,
    input  logic [CW-1:0] req_colour,
    input  logic          req_erase,
    output logic          plot,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [CW-1:0] pix_colour,
    output logic          busy,
    output logic          done
);
    import block_shooter_pkg::*;

    raster_state_t state, state_nx;

    logic [XW-1:0] x_r, x_nx;
    logic [YW-1:0] y_r, y_nx;
    logic [DW-1:0] w_r, w_nx, h_r, h_nx;
    logic [DW-1:0] i_r, i_nx, j_r, j_nx;
    logic [CW-1:0] col_r, col_nx;

    logic          plot_nx, busy_nx, done_nx, ready_nx;
    logic [XW-1:0] pix_x_nx;
    logic [YW-1:0] pix_y_nx;
    logic [CW-1:0] pix_colour_nx;

    logic          last_col, last_row;
    logic [DW-1:0] i_step, j_step;
    logic [XW-1:0] base_x;
    logic [YW-1:0] base_y;
    logic [DW-1:0] off_i, off_j;
    logic [XW:0]   sum_x;
    logic [YW:0]   sum_y;
    logic          in_frame;
    logic [CW-1:0] eff_colour;

    assign last_col   = (i_r == w_r - 1'b1);
    assign last_row   = (j_r == h_r - 1'b1);
    assign i_step     = last_col ? '0 : i_r + 1'b1;
    assign j_step     = last_col ? j_r + 1'b1 : j_r;
    assign eff_colour = req_erase ? CW'(COLOUR_BLACK) : req_colour;

    // The pixel being registered next is either the request origin (on accept) or the
    // following scan position; sums are one bit wider so off-screen pixels cannot wrap back in.
    assign base_x   = (state == SCAN) ? x_r : req_x;
    assign base_y   = (state == SCAN) ? y_r : req_y;
    assign off_i    = (state == SCAN) ? i_step : '0;
    assign off_j    = (state == SCAN) ? j_step : '0;
    assign sum_x    = {1'b0, base_x} + (XW+1)'(off_i);
    assign sum_y    = {1'b0, base_y} + (YW+1)'(off_j);
    assign in_frame = (sum_x < (XW+1)'(SCREEN_W)) && (sum_y < (YW+1)'(SCREEN_H));

    always_comb begin
        state_nx      = state;
        x_nx          = x_r;
        y_nx          = y_r;
        w_nx          = w_r;
        h_nx          = h_r;
        i_nx          = i_r;
        j_nx          = j_r;
        col_nx        = col_r;
        plot_nx       = 1'b0;
        pix_x_nx      = pix_x;
        pix_y_nx      = pix_y;
        pix_colour_nx = pix_colour;
        busy_nx       = busy;
        done_nx       = 1'b0;
        ready_nx      = req_ready;

        case (state)
            IDLE: begin
                ready_nx = 1'b1;
                busy_nx  = 1'b0;
                if (req_valid) begin
                    x_nx     = req_x;
                    y_nx     = req_y;
                    w_nx     = req_w;
                    h_nx     = req_h;
                    col_nx   = eff_colour;
                    i_nx     = '0;
                    j_nx     = '0;
                    ready_nx = 1'b0;
                    busy_nx  = 1'b1;
                    if (req_w == '0 || req_h == '0) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx      = SCAN;
                        plot_nx       = in_frame;
                        pix_x_nx      = sum_x[XW-1:0];
                        pix_y_nx      = sum_y[YW-1:0];
                        pix_colour_nx = eff_colour;
                    end
                end
            end
            SCAN: begin
                // i/j track the pixel currently on the outputs, so the last one ends the scan.
                if (last_col && last_row) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    i_nx     = '0;
                    j_nx     = '0;
                end else begin
                    i_nx          = i_step;
                    j_nx          = j_step;
                    plot_nx       = in_frame;
                    pix_x_nx      = sum_x[XW-1:0];
                    pix_y_nx      = sum_y[YW-1:0];
                    pix_colour_nx = col_r;
                end
            end
            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                ready_nx = 1'b1;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                ready_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x_r        <= '0;
            y_r        <= '0;
            w_r        <= '0;
            h_r        <= '0;
            i_r        <= '0;
            j_r        <= '0;
            col_r      <= '0;
            plot       <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            state      <= state_nx;
            x_r        <= x_nx;
            y_r        <= y_nx;
            w_r        <= w_nx;
            h_r        <= h_nx;
            i_r        <= i_nx;
            j_r        <= j_nx;
            col_r      <= col_nx;
            plot       <= plot_nx;
            pix_x      <= pix_x_nx;
            pix_y      <= pix_y_nx;
            pix_colour <= pix_colour_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            req_ready  <= ready_nx;
        end
    end

endmodule

// File: tb/tb_rect_raster.sv
// Directed bench for rect_raster: fixed requests with hand-computed pixel streams,
// clipping at the frame corner, zero-size, back-to-back, reset abort and input stability.
module tb_rect_raster;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [4:0] req_w;
    logic [4:0] req_h;
    logic [2:0] req_colour;
    logic       req_erase;
    logic       plot;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    rect_raster dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .req_erase  (req_erase),
        .plot       (plot),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkPixel(input string tag, input logic p, input int x, input int y, input int c);
        checkOutput({tag, ".plot"}, 16'(plot), 16'(p));
        checkOutput({tag, ".x"}, 16'(pix_x), 16'(x));
        checkOutput({tag, ".y"}, 16'(pix_y), 16'(y));
        checkOutput({tag, ".colour"}, 16'(pix_colour), 16'(c));
    endtask

    task automatic checkStatus(input string tag, input logic rdy, input logic bsy, input logic dn, input logic p);
        checkOutput({tag, ".req_ready"}, 16'(req_ready), 16'(rdy));
        checkOutput({tag, ".busy"}, 16'(busy), 16'(bsy));
        checkOutput({tag, ".done"}, 16'(done), 16'(dn));
        checkOutput({tag, ".plot"}, 16'(plot), 16'(p));
    endtask

    // Called on a negedge; waits a bounded number of cycles for the block to be idle.
    task automatic waitReady(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout waiting for req_ready observed=%0d expected=1", tag, req_ready);
        end
    endtask

    // Presents a request at a negedge, lets the accept edge pass and returns at the negedge
    // of the first cycle after accept (where the first pixel should be visible).
    task automatic applyStimulus(input string tag, input int x, input int y, input int w, input int h,
                                 input int c, input logic erase, input logic hold);
        waitReady(tag);
        req_x      = 8'(x);
        req_y      = 7'(y);
        req_w      = 5'(w);
        req_h      = 5'(h);
        req_colour = 3'(c);
        req_erase  = erase;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_w      = '0;
        req_h      = '0;
        req_colour = '0;
        req_erase  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkStatus("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        checkPixel("reset", 1'b0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);

        // 3x2 rectangle at (10,20), colour 101
        applyStimulus("rect3x2", 10, 20, 3, 2, 5, 1'b0, 1'b0);
        checkPixel("rect3x2.p0", 1'b1, 10, 20, 5);
        checkOutput("rect3x2.busy", 16'(busy), 16'd1);
        checkOutput("rect3x2.ready", 16'(req_ready), 16'd0);
        @(negedge clk); checkPixel("rect3x2.p1", 1'b1, 11, 20, 5);
        @(negedge clk); checkPixel("rect3x2.p2", 1'b1, 12, 20, 5);
        @(negedge clk); checkPixel("rect3x2.p3", 1'b1, 10, 21, 5);
        @(negedge clk); checkPixel("rect3x2.p4", 1'b1, 11, 21, 5);
        @(negedge clk); checkPixel("rect3x2.p5", 1'b1, 12, 21, 5);
        @(negedge clk); checkStatus("rect3x2.done", 1'b0, 1'b1, 1'b1, 1'b0);
        checkPixel("rect3x2.hold", 1'b0, 12, 21, 5);
        @(negedge clk); checkStatus("rect3x2.idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // 4x4 erase at the bottom-right corner: only the 2x2 inside the frame plots
        applyStimulus("corner", 158, 118, 4, 4, 7, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r != 0 || c != 0) @(negedge clk);
                checkPixel($sformatf("corner.r%0dc%0d", r, c),
                           ((158 + c) < 160) && ((118 + r) < 120), 158 + c, 118 + r, 0);
            end
        end
        @(negedge clk); checkStatus("corner.done", 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); checkStatus("corner.idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // zero width: done right after accept, no pixels
        applyStimulus("zero", 40, 30, 0, 5, 2, 1'b0, 1'b0);
        checkStatus("zero.done", 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); checkStatus("zero.idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // back-to-back with req_valid held; B is presented while A is still scanning
        applyStimulus("b2b", 5, 5, 2, 1, 3, 1'b0, 1'b1);
        req_x      = 8'd30;
        req_y      = 7'd40;
        req_w      = 5'd1;
        req_h      = 5'd1;
        req_colour = 3'd6;
        checkPixel("b2b.a0", 1'b1, 5, 5, 3);
        @(negedge clk); checkPixel("b2b.a1", 1'b1, 6, 5, 3);
        @(negedge clk); checkStatus("b2b.a_done", 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); checkStatus("b2b.gap", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checkPixel("b2b.b0", 1'b1, 30, 40, 6);
        req_valid = 1'b0;
        @(negedge clk); checkStatus("b2b.b_done", 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); checkStatus("b2b.idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // reset during the 5th pixel of a 10x10 aborts without done
        applyStimulus("abort", 0, 0, 10, 10, 2, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); checkPixel("abort.p4", 1'b1, 4, 0, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkStatus("abort.reset", 1'b1, 1'b0, 1'b0, 1'b0);
        checkPixel("abort.reset", 1'b0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkStatus($sformatf("abort.quiet%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus("fresh", 7, 8, 1, 1, 4, 1'b0, 1'b0);
        checkPixel("fresh.p0", 1'b1, 7, 8, 4);
        @(negedge clk); checkStatus("fresh.done", 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); checkStatus("fresh.idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // inputs changed during the scan must not affect the pixels
        applyStimulus("stable", 50, 60, 4, 1, 1, 1'b0, 1'b0);
        req_x      = 8'd100;
        req_y      = 7'd10;
        req_colour = 3'd7;
        req_erase  = 1'b1;
        checkPixel("stable.p0", 1'b1, 50, 60, 1);
        @(negedge clk); checkPixel("stable.p1", 1'b1, 51, 60, 1);
        @(negedge clk); checkPixel("stable.p2", 1'b1, 52, 60, 1);
        @(negedge clk); checkPixel("stable.p3", 1'b1, 53, 60, 1);
        @(negedge clk); checkStatus("stable.done", 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); checkStatus("stable.idle", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
